// File: rtl/servo_ramp_ctrl_if.sv
// servo_ramp_ctrl_if: command handshake plus the PWM-facing outputs of servo_ramp_ctrl.
// master drives commands; slave is the ramp controller.
interface servo_ramp_ctrl_if #(
  parameter int W = 32
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_width;
  logic [W-1:0] width_out;
  logic         period_start;
  logic         at_target;
  logic         cmd_clamped;

  modport master (
    output cmd_valid,
    output cmd_width,
    input  cmd_ready,
    input  width_out,
    input  period_start,
    input  at_target,
    input  cmd_clamped
  );

  modport slave (
    input  cmd_valid,
    input  cmd_width,
    output cmd_ready,
    output width_out,
    output period_start,
    output at_target,
    output cmd_clamped
  );
endinterface

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: clamps commanded servo pulse widths and moves width_out toward them only on
// PWM period boundaries. Define SERVO_RAMP_SLEW_EN to limit each update to STEP clocks.
module servo_ramp_ctrl #(
  parameter int W             = 32,
  parameter int PERIOD_CYCLES = 1000000,
  parameter int MIN_WIDTH     = 50000,
  parameter int MAX_WIDTH     = 100000,
  parameter int STEP          = 500
) (
  input  logic              clock_clk,
  input  logic              reset_low,
  servo_ramp_ctrl_if.slave  bus
);

  // state | meaning
  // HOLD  | width_out equals target
  // RAMP  | width_out differs from target; moves on each period tick

  typedef enum logic [0:0] {
    HOLD = 1'b0,
    RAMP = 1'b1
  } state_t;

`ifdef SERVO_RAMP_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam int               CNT_W    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [W-1:0]     MIN_W    = W'(MIN_WIDTH);
  localparam logic [W-1:0]     MAX_W    = W'(MAX_WIDTH);
  localparam logic [W-1:0]     NEUTRAL  = W'((MIN_WIDTH + MAX_WIDTH) / 2);
  localparam logic [W-1:0]     STEP_W   = W'(STEP);
  // With slew limiting off, every difference is treated as reachable in one update.
  localparam logic [W:0]       STEP_LIM = SLEW_EN ? (W+1)'(STEP) : '1;

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] period_cnt;
  logic             tick;
  logic [W-1:0]     width_q;
  logic [W-1:0]     width_nxt;
  logic [W-1:0]     target_q;
  logic [W-1:0]     target_nxt;
  logic [W-1:0]     cmd_target;
  logic [W-1:0]     ramp_width;
  logic             accept;
  logic             cmd_low;
  logic             cmd_high;
  logic             tgt_above;
  logic [W:0]       diff_mag;
  logic             within_step;
  logic             cmd_ready_q;
  logic             period_start_q;
  logic             at_target_q;
  logic             cmd_clamped_q;

  assign tick       = (period_cnt == '0);
  assign accept     = bus.cmd_valid && cmd_ready_q;
  assign cmd_low    = (bus.cmd_width < MIN_W);
  assign cmd_high   = (bus.cmd_width > MAX_W);
  assign cmd_target = cmd_low ? MIN_W : (cmd_high ? MAX_W : bus.cmd_width);

  // Magnitude taken one bit wider so neither direction can wrap.
  assign tgt_above   = (target_q > width_q);
  assign diff_mag    = tgt_above ? ({1'b0, target_q} - {1'b0, width_q})
                                 : ({1'b0, width_q} - {1'b0, target_q});
  assign within_step = (diff_mag <= STEP_LIM);
  assign ramp_width  = within_step ? target_q
                                   : (tgt_above ? (width_q + STEP_W) : (width_q - STEP_W));

  // Down-counter: terminal count zero is the last cycle of the period.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      period_cnt <= CNT_LAST;
    end else if (tick) begin
      period_cnt <= CNT_LAST;
    end else begin
      period_cnt <= period_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q  <= HOLD;
      width_q  <= NEUTRAL;
      target_q <= NEUTRAL;
    end else begin
      state_q  <= state_nxt;
      width_q  <= width_nxt;
      target_q <= target_nxt;
    end
  end

  // The tick works from the pre-edge target; a command on the same edge applies next period.
  always_comb begin
    state_nxt  = state_q;
    width_nxt  = width_q;
    target_nxt = target_q;
    if (tick && (state_q == RAMP)) begin
      width_nxt = ramp_width;
    end
    if (accept) begin
      target_nxt = cmd_target;
    end
    case (state_q)
      HOLD: if (target_nxt != width_nxt) state_nxt = RAMP;
      RAMP: if (target_nxt == width_nxt) state_nxt = HOLD;
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      cmd_ready_q    <= 1'b0;
      period_start_q <= 1'b0;
      at_target_q    <= 1'b1;
      cmd_clamped_q  <= 1'b0;
    end else begin
      cmd_ready_q    <= 1'b1;
      period_start_q <= tick;
      at_target_q    <= (state_nxt == HOLD);
      cmd_clamped_q  <= accept && (cmd_low || cmd_high);
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.width_out    = width_q;
  assign bus.period_start = period_start_q;
  assign bus.at_target    = at_target_q;
  assign bus.cmd_clamped  = cmd_clamped_q;

endmodule
